variable_latency_tgt_queue: RTL
===============================

VARIABLE_LATENCY_TGT_QUEUE -- requirements
Module: variable_latency_tgt_queue

Interface
REQ-001 The block SHALL have parameter NumTgt, default 16: number of independent target channels.
REQ-002 The block SHALL have parameter NumIn, default 32: number of initiators; IniW = $clog2(NumIn).
REQ-003 The block SHALL have parameter DataWidth, default 32: response data width.
REQ-004 The block SHALL have parameter NumOutstanding, default 4: response buffer depth and maximum credits per channel; CntW = $clog2(NumOutstanding+1).
REQ-005 The block SHALL have parameter FallThrough, default 1'b0: 1 means a response may pass the buffer in the cycle it arrives.
REQ-006 The block SHALL have parameter WriteRespOn, default 1'b1: 1 means writes consume a credit.
REQ-007 The block SHALL have one clock and a synchronous active-high reset; the ports are clk_i (input, 1, clock) and rst_i (input, 1, reset).
REQ-008 limit_i  input  NumTgt x CntW  runtime credit limit per channel; 0 or any value > NumOutstanding means NumOutstanding.
REQ-009 net_req_i  input  NumTgt  request from the network toward each target.
REQ-010 req_o  output  NumTgt  gated request to each target.
REQ-011 gnt_i  input  NumTgt  target accepted the request.
REQ-012 wen_i  input  NumTgt  write enable of the current request.
REQ-013 vld_i  input  NumTgt  target response valid; this port has no backpressure.
REQ-014 ini_add_i  input  NumTgt x IniW  initiator index returned with the response.
REQ-015 rdata_i  input  NumTgt x DataWidth  response data.
REQ-016 resp_vld_o  output  NumTgt  a buffered response is available to the network.
REQ-017 resp_rdy_i  input  NumTgt  the network pops the response.
REQ-018 resp_ini_add_o  output  NumTgt x IniW  initiator index of the head response.
REQ-019 resp_rdata_o  output  NumTgt x DataWidth  data of the head response.
REQ-020 drain_req_i  input  NumTgt  request to quiesce the channel.
REQ-021 drain_ack_o  output  NumTgt  the channel is quiesced.
REQ-022 ovf_o  output  NumTgt  sticky error: a response arrived while the buffer was full.

Function (per channel k; channels fully independent)
REQ-023 The buffer SHALL be a circular buffer of NumOutstanding entries {rdata, ini_add}; the read and write pointers SHALL wrap from NumOutstanding-1 to 0, and a separate count SHALL distinguish full from empty.
REQ-024 push = vld_i & ~buf_full; pop = resp_vld_o & resp_rdy_i.
REQ-025 When push and pop occur together on a full buffer, both SHALL occur and the count SHALL be unchanged.
REQ-026 resp_vld_o SHALL equal ~buf_empty; additionally, if FallThrough=1, the buffer is empty and vld_i=1, resp_vld_o=1 SHALL carry the inputs in the same cycle.
REQ-027 In the REQ-026 fall-through case, the entry SHALL be written only if resp_rdy_i=0.
REQ-028 With FallThrough=0, the minimum latency from vld_i to resp_vld_o SHALL be 1 cycle.
REQ-029 vld_i while the buffer is full and no pop occurs SHALL drop the data and set ovf_o; ovf_o SHALL clear only on reset.
REQ-030 The credit counter usage SHALL increment when gnt_i & (~wen_i | WriteRespOn).
REQ-031 usage SHALL decrement on pop if FallThrough=1, or on pop registered one cycle later if FallThrough=0; simultaneous increment and decrement SHALL leave it unchanged.
REQ-032 cred_full SHALL be usage >= eff_limit; req_o SHALL equal net_req_i & ~cred_full & (state==IDLE).
REQ-033 Lowering limit_i below the current usage SHALL only block new requests; in-flight credits SHALL be unaffected.
REQ-034 gnt_i without req_o SHALL still be counted, and gnt_i while usage==NumOutstanding SHALL saturate the counter and set ovf_o.
REQ-035 The drain FSM SHALL have states IDLE, DRAIN and DONE.
REQ-036 IDLE SHALL go to DRAIN on drain_req_i.
REQ-037 DRAIN SHALL hold req_o=0 and go to DONE when usage==0, the buffer is empty and no registered pop is pending.
REQ-038 DONE SHALL assert drain_ack_o and go to IDLE when drain_req_i=0.
REQ-039 Deasserting drain_req_i in DRAIN SHALL return the FSM to IDLE without ack.
REQ-040 In DRAIN and DONE, responses SHALL still be accepted and delivered.

Reset
REQ-041 When rst_i=1 at a clock edge, pointers, count, usage, registered pop, ovf_o and state SHALL go to 0/IDLE, whether idle or mid-operation.
REQ-042 During reset, req_o=0, resp_vld_o=0 and drain_ack_o=0; buffered data SHALL be discarded.
REQ-043 Buffer data storage SHALL NOT be reset.

Structure
REQ-044 The drain state enum and a helper function computing the effective limit SHALL reside in tcdm_interconnect_pkg.
REQ-045 A single sub-module, variable_latency_tgt_chan (buffer, credit counter and FSM for one channel), SHALL be generated NumTgt times.
REQ-046 Elaboration SHALL fail with $fatal if NumOutstanding==0 or NumIn<2.

Verification
REQ-047 Credit limit: NumOutstanding=4, limit_i=2, net_req_i and gnt_i held high, reads, no responses -> two grants, then req_o=0 and usage=2.
REQ-048 FallThrough=1, buffer empty, vld_i with rdata=0xA5A5A5A5, ini=3 and resp_rdy_i=1 -> resp_vld_o with the same data in that cycle; the count stays 0.
REQ-049 FallThrough=0, 4 responses pushed and resp_rdy_i=0, then a 5th push -> ovf_o=1, the head stays the first response, and the remaining 4 pops are in order.
REQ-050 Wrap-around: 10 push/pop pairs at depth 4 -> data order preserved, no overflow.
REQ-051 Drain: usage=3, drain_req_i=1 -> req_o=0; after 3 pops (+1 cycle if FallThrough=0) drain_ack_o=1; drop drain_req_i -> IDLE next cycle.
REQ-052 WriteRespOn=0: 4 write grants -> usage stays 0 and req_o stays high.

Source files
------------

// File: rtl/tcdm_interconnect_pkg.sv
// Shared types and helpers for the variable-latency target queue.
package tcdm_interconnect_pkg;

    // Per-channel drain sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_e;

    // A runtime limit of zero, or one above the buffer depth, means "use the full depth".
    function automatic int eff_limit(input int limit, input int max_out);
        if ((limit == 0) || (limit > max_out)) begin
            return max_out;
        end
        return limit;
    endfunction

endpackage

// File: rtl/variable_latency_tgt_chan.sv
// One target channel: response circular buffer, credit counter and drain FSM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal operation, requests pass when credits are available
// ST_DRAIN | new requests blocked, waiting for in-flight work to finish
// ST_DONE  | channel quiesced, drain_ack_o asserted until request drops
module variable_latency_tgt_chan
    import tcdm_interconnect_pkg::*;
#(
    parameter int  NumIn          = 32,
    parameter int  DataWidth      = 32,
    parameter int  NumOutstanding = 4,
    parameter bit  FallThrough    = 1'b0,
    parameter bit  WriteRespOn    = 1'b1,
    localparam int IniW           = $clog2(NumIn),
    localparam int CntW           = $clog2(NumOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CntW-1:0]      limit_i,
    input  logic                 net_req_i,
    output logic                 req_o,
    input  logic                 gnt_i,
    input  logic                 wen_i,
    input  logic                 vld_i,
    input  logic [IniW-1:0]      ini_add_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 resp_vld_o,
    input  logic                 resp_rdy_i,
    output logic [IniW-1:0]      resp_ini_add_o,
    output logic [DataWidth-1:0] resp_rdata_o,
    input  logic                 drain_req_i,
    output logic                 drain_ack_o,
    output logic                 ovf_o
);

    localparam int              PtrW    = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NumOutstanding - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(NumOutstanding);

    logic [DataWidth-1:0] r_mem_data [NumOutstanding];
    logic [IniW-1:0]      r_mem_ini  [NumOutstanding];
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [CntW-1:0]      r_count;
    logic [CntW-1:0]      r_usage;
    logic                 r_pop_q;
    logic                 r_ovf;
    drain_state_e         r_state;
    drain_state_e         w_state_nxt;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_ft;
    logic                 w_resp_vld;
    logic                 w_pop;
    logic                 w_buf_pop;
    logic                 w_write;
    logic                 w_drop;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_sat;
    logic                 w_pop_pend;
    logic                 w_drained;
    logic                 w_cred_full;
    logic [CntW-1:0]      w_limit;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == MaxCnt);
    // Bypass only exists when nothing older is queued ahead of the arriving response.
    assign w_ft       = FallThrough & w_empty & vld_i;
    assign w_resp_vld = ~rst_i & (~w_empty | w_ft);
    assign w_pop      = w_resp_vld & resp_rdy_i;
    assign w_buf_pop  = w_pop & ~w_empty;
    // A pop from a full buffer frees the slot the concurrent arrival takes.
    assign w_write    = vld_i & (~w_full | w_buf_pop) & ~(w_ft & resp_rdy_i);
    assign w_drop     = vld_i & w_full & ~w_buf_pop;

    assign w_inc      = gnt_i & (~wen_i | WriteRespOn);
    assign w_dec      = FallThrough ? w_pop : r_pop_q;
    assign w_sat      = w_inc & ~w_dec & (r_usage == MaxCnt);

    assign w_limit     = CntW'(eff_limit(int'(limit_i), NumOutstanding));
    assign w_cred_full = (r_usage >= w_limit);
    assign w_pop_pend  = ~FallThrough & r_pop_q;
    assign w_drained   = (r_usage == '0) & w_empty & ~w_pop_pend;

    // Response storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem_data[r_wr_ptr] <= rdata_i;
            r_mem_ini[r_wr_ptr]  <= ini_add_i;
        end
    end

    // Buffer pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_buf_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_write, w_buf_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outstanding-credit counter, saturating at the buffer depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_usage <= '0;
            r_pop_q <= 1'b0;
        end else begin
            r_pop_q <= w_pop;
            if (w_inc & ~w_dec & ~w_sat) begin
                r_usage <= r_usage + 1'b1;
            end else if (w_dec & ~w_inc & (r_usage != '0)) begin
                r_usage <= r_usage - 1'b1;
            end
        end
    end

    // Sticky error: dropped response or credit counter saturation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop | w_sat) begin
            r_ovf <= 1'b1;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (drain_req_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain_req_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_drained) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!drain_req_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign req_o          = ~rst_i & net_req_i & ~w_cred_full & (r_state == ST_IDLE);
    assign drain_ack_o    = ~rst_i & (r_state == ST_DONE);
    assign resp_vld_o     = w_resp_vld;
    assign resp_ini_add_o = w_ft ? ini_add_i : r_mem_ini[r_rd_ptr];
    assign resp_rdata_o   = w_ft ? rdata_i : r_mem_data[r_rd_ptr];
    assign ovf_o          = r_ovf;

endmodule

// File: rtl/variable_latency_tgt_queue.sv
// Array of independent target channels, each with credit gating and a response buffer.
module variable_latency_tgt_queue
    import tcdm_interconnect_pkg::*;
#(
    parameter int  NumTgt         = 16,
    parameter int  NumIn          = 32,
    parameter int  DataWidth      = 32,
    parameter int  NumOutstanding = 4,
    parameter bit  FallThrough    = 1'b0,
    parameter bit  WriteRespOn    = 1'b1,
    localparam int IniW           = $clog2(NumIn),
    localparam int CntW           = $clog2(NumOutstanding + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumTgt-1:0][CntW-1:0]      limit_i,
    input  logic [NumTgt-1:0]                net_req_i,
    output logic [NumTgt-1:0]                req_o,
    input  logic [NumTgt-1:0]                gnt_i,
    input  logic [NumTgt-1:0]                wen_i,
    input  logic [NumTgt-1:0]                vld_i,
    input  logic [NumTgt-1:0][IniW-1:0]      ini_add_i,
    input  logic [NumTgt-1:0][DataWidth-1:0] rdata_i,
    output logic [NumTgt-1:0]                resp_vld_o,
    input  logic [NumTgt-1:0]                resp_rdy_i,
    output logic [NumTgt-1:0][IniW-1:0]      resp_ini_add_o,
    output logic [NumTgt-1:0][DataWidth-1:0] resp_rdata_o,
    input  logic [NumTgt-1:0]                drain_req_i,
    output logic [NumTgt-1:0]                drain_ack_o,
    output logic [NumTgt-1:0]                ovf_o
);

    if ((NumOutstanding == 0) || (NumIn < 2)) begin : g_param_chk
        $fatal(1, "variable_latency_tgt_queue: NumOutstanding must be > 0 and NumIn >= 2");
    end

    for (genvar k = 0; k < NumTgt; k++) begin : g_chan
        variable_latency_tgt_chan #(
            .NumIn          (NumIn),
            .DataWidth      (DataWidth),
            .NumOutstanding (NumOutstanding),
            .FallThrough    (FallThrough),
            .WriteRespOn    (WriteRespOn)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .limit_i        (limit_i[k]),
            .net_req_i      (net_req_i[k]),
            .req_o          (req_o[k]),
            .gnt_i          (gnt_i[k]),
            .wen_i          (wen_i[k]),
            .vld_i          (vld_i[k]),
            .ini_add_i      (ini_add_i[k]),
            .rdata_i        (rdata_i[k]),
            .resp_vld_o     (resp_vld_o[k]),
            .resp_rdy_i     (resp_rdy_i[k]),
            .resp_ini_add_o (resp_ini_add_o[k]),
            .resp_rdata_o   (resp_rdata_o[k]),
            .drain_req_i    (drain_req_i[k]),
            .drain_ack_o    (drain_ack_o[k]),
            .ovf_o          (ovf_o[k])
        );
    end

endmodule
